sccb_slave: RTL

SCCB_SLAVE -- requirements
Module: sccb_slave

---
 rtl/sccb_slave_if.sv | 23 ++
 rtl/sccb_slave.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sccb_slave_if.sv
// SCCB pins and register-file port of sccb_slave, grouped into one bundle.
// The slave modport drives SIOD/register outputs; the master side drives the bus and read data.
interface sccb_slave_if;
    logic       sioc;
    logic       siod_in;
    logic       siod_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;

    modport slave (
        input  sioc, siod_in, reg_rdata,
        output siod_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
    );

    modport master (
        output sioc, siod_in, reg_rdata,
        input  siod_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
    );
endinterface

// File: rtl/sccb_slave.sv
// SCCB (I2C-like) register-access slave: oversamples SIOC/SIOD on clk, decodes START/STOP,
// acks device-ID/sub-address/write bytes and serves sequential reads from a combinational register file.
module sccb_slave #(
    parameter logic [6:0] DEV_ID = 7'h21
) (
    input  logic        clk,
    input  logic        rstn,
    sccb_slave_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_NA, IGNORE
    } state_t;

    state_t      state_q, state_d;
    // [0],[1] are the synchronizer stages, [2] is the history flop for edge detection
    logic [2:0]  sioc_sync_q, siod_sync_q;
    logic [3:0]  cnt_q, cnt_d;
    logic [6:0]  sh_q, sh_d;
    logic [6:0]  tx_q, tx_d;
    logic        rw_q, rw_d;
    logic        na_q, na_d;
    logic        oe_q, oe_d;
    logic        we_q, we_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;

    logic        sioc_rise, sioc_fall, start_det, stop_det, load_tx;
    logic [7:0]  rx_byte;

    assign sioc_rise = sioc_sync_q[1] & ~sioc_sync_q[2];
    assign sioc_fall = ~sioc_sync_q[1] & sioc_sync_q[2];
    assign start_det = sioc_sync_q[1] & sioc_sync_q[2] & siod_sync_q[2] & ~siod_sync_q[1];
    assign stop_det  = sioc_sync_q[1] & sioc_sync_q[2] & ~siod_sync_q[2] & siod_sync_q[1];
    assign rx_byte   = {sh_q, siod_sync_q[1]};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sioc_sync_q <= 3'b111;
            siod_sync_q <= 3'b111;
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            sh_q        <= 7'd0;
            tx_q        <= 7'd0;
            rw_q        <= 1'b0;
            na_q        <= 1'b0;
            oe_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
        end else begin
            sioc_sync_q <= {sioc_sync_q[1:0], bus.sioc};
            siod_sync_q <= {siod_sync_q[1:0], bus.siod_in};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            tx_q        <= tx_d;
            rw_q        <= rw_d;
            na_q        <= na_d;
            oe_q        <= oe_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    // Bus conditions outrank bit handling; ack states use cnt_q as "ack already driven".
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        rw_d    = rw_q;
        na_d    = na_q;
        oe_d    = oe_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (start_det) begin
            state_d = ID;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
        end else if (stop_det) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
        end else begin
            unique case (state_q)
                ID, SUB, WDATA: begin
                    if (sioc_rise) begin
                        sh_d  = rx_byte[6:0];
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d = 4'd0;
                            if (state_q == ID) begin
                                if (rx_byte[7:1] == DEV_ID) begin
                                    state_d = ID_ACK;
                                    rw_d    = rx_byte[0];
                                end else begin
                                    state_d = IGNORE;
                                end
                            end else if (state_q == SUB) begin
                                addr_d  = rx_byte;
                                state_d = SUB_ACK;
                            end else begin
                                wdata_d = rx_byte;
                                we_d    = 1'b1;
                                state_d = WDATA_ACK;
                            end
                        end
                    end
                end
                ID_ACK, SUB_ACK, WDATA_ACK: begin
                    if (sioc_fall) begin
                        if (cnt_q == 4'd0) begin
                            oe_d  = 1'b1;
                            cnt_d = 4'd1;
                        end else begin
                            oe_d  = 1'b0;
                            cnt_d = 4'd0;
                            if (state_q == ID_ACK) begin
                                if (rw_q) begin
                                    state_d = RDATA;
                                    tx_d    = bus.reg_rdata[6:0];
                                    oe_d    = ~bus.reg_rdata[7];
                                end else begin
                                    state_d = SUB;
                                end
                            end else if (state_q == SUB_ACK) begin
                                state_d = WDATA;
                            end else begin
                                state_d = WDATA;
                                addr_d  = addr_q + 8'd1;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (sioc_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (sioc_fall) begin
                        if (cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            cnt_d   = 4'd0;
                            state_d = RDATA_NA;
                        end else begin
                            tx_d = {tx_q[5:0], 1'b0};
                            oe_d = ~tx_q[6];
                        end
                    end
                end
                RDATA_NA: begin
                    // Address advances on the ACK sample so reg_rdata is already valid at reload.
                    if (sioc_rise) begin
                        na_d  = siod_sync_q[1];
                        cnt_d = 4'd1;
                        if (!siod_sync_q[1]) addr_d = addr_q + 8'd1;
                    end else if (sioc_fall && cnt_q == 4'd1) begin
                        cnt_d = 4'd0;
                        if (na_q) begin
                            state_d = IGNORE;
                        end else begin
                            state_d = RDATA;
                            tx_d    = bus.reg_rdata[6:0];
                            oe_d    = ~bus.reg_rdata[7];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        load_tx = 1'b0;
        if (!start_det && !stop_det && sioc_fall && cnt_q == 4'd1) begin
            if (state_q == ID_ACK && rw_q)    load_tx = 1'b1;
            if (state_q == RDATA_NA && !na_q) load_tx = 1'b1;
        end
        bus.reg_re    = load_tx;
        bus.busy      = (state_q != IDLE);
        bus.siod_oe   = oe_q;
        bus.reg_we    = we_q;
        bus.reg_addr  = addr_q;
        bus.reg_wdata = wdata_q;
    end
endmodule
